// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side streamer: controller state
// encoding, the FIFO read latency and default data width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Read-side controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } fsm_state_e;

    // Cycles from fifo_rd_en to fifo_rdata being valid
    localparam int RD_LAT = 1;

    // Default data word width, matches the FIFO
    localparam int DEFAULT_WIDTH = 8;

    // Words the output buffer must hold to cover the read latency at full rate
    localparam int OUT_BUF_DEPTH = RD_LAT + 1;

    // Buffered words plus the word still travelling out of the RAM
    function automatic logic [2:0] occupancy(input logic [1:0] buf_cnt,
                                             input logic       inflight);
        return {1'b0, buf_cnt} + {2'b00, inflight};
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// -----------------------------------------------------------------------------
// stream_skid_buf
// Two-entry in-order buffer holding data plus a last flag. Entry 0 is always
// the head, so the head word sits in a fixed register and stays stable while
// the consumer stalls. A push and a pop in the same cycle are both honoured.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i          write push_data_i/push_last_i at the tail
//   push_data_i     word to write
//   push_last_i     last flag travelling with the word
//   pop_i           remove the head word
//   cnt_o           number of stored words (0..2)
//   head_data_o     head word
//   head_last_o     last flag of the head word
// -----------------------------------------------------------------------------
module stream_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_last_i,
    input  logic             pop_i,
    output logic [1:0]       cnt_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_last_o
);

    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             last0_q, last0_d, last1_q, last1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_ok_s, push_ok_s;

    // Next-state for the entries and count; pops shift entry 1 into the head
    always_comb begin
        data0_d   = data0_q;
        data1_d   = data1_q;
        last0_d   = last0_q;
        last1_d   = last1_q;
        cnt_d     = cnt_q;
        pop_ok_s  = pop_i && (cnt_q != 2'd0);
        // A full buffer can still accept a word when the head leaves this cycle
        push_ok_s = push_i && ((cnt_q != 2'd2) || pop_ok_s);
        case ({push_ok_s, pop_ok_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    data0_d = push_data_i;
                    last0_d = push_last_i;
                end else begin
                    data1_d = push_data_i;
                    last1_d = push_last_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    data0_d = push_data_i;
                    last0_d = push_last_i;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = push_data_i;
                    last1_d = push_last_i;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Entry and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign head_data_o = data0_q;
    assign head_last_o = last0_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// -----------------------------------------------------------------------------
// fifo_rd_streamer
// Drains req_len words from a synchronous FIFO (1-cycle read latency) and
// presents them on a valid/ready stream with a last marker. A 2-entry output
// buffer absorbs the read latency so a burst runs at one word per cycle and
// survives backpressure without losing data.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid, req_len, req_ready burst request handshake (ready only in IDLE)
//   fifo_empty                    FIFO empty flag
//   fifo_rd_cs, fifo_rd_en        FIFO read port strobes (one pop per cycle)
//   fifo_rdata                    read data, valid 1 cycle after fifo_rd_en
//   m_valid, m_ready              output stream handshake
//   m_data, m_last                output word and end-of-burst marker
//   busy                          high while a burst is open
//   done                          one-cycle pulse after the burst completes
// -----------------------------------------------------------------------------
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LEN_W     = 4,
    parameter int BUF_DEPTH = OUT_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             fifo_empty,
    output logic             fifo_rd_cs,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0]       DEPTH_C = 3'(BUF_DEPTH);
    localparam logic [LEN_W-1:0] ONE_C   = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO_C  = LEN_W'(0);

    fsm_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_issue_q, rem_issue_d;
    logic [LEN_W-1:0] rem_out_q, rem_out_d;
    logic             inflight_q, inflight_last_q;
    logic             done_q, done_d;

    logic [1:0]       buf_cnt_s;
    logic [WIDTH-1:0] head_data_s;
    logic             head_last_s;
    logic             pop_out_s;
    logic             room_s;
    logic             rd_en_s;

    assign m_valid   = (buf_cnt_s != 2'd0);
    assign pop_out_s = m_valid && m_ready;

    // A word leaving this cycle frees a slot for a pop issued in the same cycle
    assign room_s  = occupancy(buf_cnt_s, inflight_q) < (DEPTH_C + {2'b00, pop_out_s});
    assign rd_en_s = (state_q == ACTIVE) && !fifo_empty && (rem_issue_q != ZERO_C) && room_s;

    // Controller next-state, burst counters and done pulse
    always_comb begin
        state_d     = state_q;
        rem_issue_d = rem_issue_q;
        rem_out_d   = rem_out_q;
        done_d      = 1'b0;
        if (pop_out_s && (rem_out_q != ZERO_C)) begin
            rem_out_d = rem_out_q - ONE_C;
        end else begin
            rem_out_d = rem_out_q;
        end
        case (state_q)
            IDLE: begin
                if (req_valid && (req_len != ZERO_C)) begin
                    rem_issue_d = req_len;
                    rem_out_d   = req_len;
                    state_d     = ACTIVE;
                end else if (req_valid) begin
                    // Zero-length burst: acknowledge without touching the FIFO
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (rd_en_s) begin
                    rem_issue_d = rem_issue_q - ONE_C;
                    if (rem_issue_q == ONE_C) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ACTIVE;
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            DRAIN: begin
                if (pop_out_s && (rem_out_q == ONE_C)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; the in-flight flag marks read data due next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rem_issue_q     <= ZERO_C;
            rem_out_q       <= ZERO_C;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rem_issue_q     <= rem_issue_d;
            rem_out_q       <= rem_out_d;
            inflight_q      <= rd_en_s;
            inflight_last_q <= rd_en_s && (rem_issue_q == ONE_C);
            done_q          <= done_d;
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_rdata),
        .push_last_i (inflight_last_q),
        .pop_i       (pop_out_s),
        .cnt_o       (buf_cnt_s),
        .head_data_o (head_data_s),
        .head_last_o (head_last_s)
    );

    assign fifo_rd_en = rd_en_s;
    assign fifo_rd_cs = rd_en_s;
    assign m_data     = head_data_s;
    assign m_last     = m_valid && head_last_s;
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_streamer
// Directed bench for fifo_rd_streamer with a simple FIFO read-port model
// (1-cycle read latency) and a handshake recorder.
// -----------------------------------------------------------------------------
module tb_fifo_rd_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid;
    logic [3:0] req_len;
    logic       req_ready;
    logic       fifo_empty;
    logic       fifo_rd_cs;
    logic       fifo_rd_en;
    logic [7:0] fifo_rdata = 8'h00;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    fifo_rd_streamer #(.WIDTH(8), .LEN_W(4), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .fifo_empty (fifo_empty),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by the stimulus, popped by fifo_rd_en
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Read port with one cycle of latency
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= mem[rd_ptr[5:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Recorder: pops, accepted words, and outstanding words (buffered + in flight)
    int pops = 0;
    int hs = 0;
    int occ = 0;
    logic [7:0] got_data [0:255];
    logic       got_last [0:255];
    always @(posedge clk) begin
        if (fifo_rd_en) pops <= pops + 1;
        if (m_valid && m_ready) begin
            got_data[hs[7:0]] <= m_data;
            got_last[hs[7:0]] <= m_last;
            hs <= hs + 1;
        end
        if (rst) occ <= 0;
        else     occ <= occ + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end

    // Sticky flag for the buffer ever holding more than two words
    logic occ_ovf = 1'b0;
    always @(negedge clk) begin
        if (occ > 2) occ_ovf = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_done(input int max_cyc, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
    endtask

    // {busy, cs, rd_en, m_valid, m_last, done, data-if-valid}
    function automatic logic [13:0] obs();
        return {busy, fifo_rd_cs, fifo_rd_en, m_valid, m_last, done,
                (m_valid ? m_data : 8'h00)};
    endfunction

    logic [13:0] basic_exp [0:6];
    logic        seen;
    logic        acc;
    int          p0;
    int          h0;

    initial begin
        basic_exp[0] = {6'b111000, 8'h00};
        basic_exp[1] = {6'b111000, 8'h00};
        basic_exp[2] = {6'b111100, 8'h11};
        basic_exp[3] = {6'b100100, 8'h22};
        basic_exp[4] = {6'b100110, 8'h33};
        basic_exp[5] = {6'b000001, 8'h00};
        basic_exp[6] = {6'b000000, 8'h00};

        req_valid = 1'b0;
        req_len   = 4'd0;
        m_ready   = 1'b0;
        rst       = 1'b1;
        repeat (2) step();
        check("reset_outputs",
              32'({req_ready, fifo_rd_cs, fifo_rd_en, m_valid, m_last, busy, done, m_data}),
              32'({7'b1000000, 8'h00}));
        rst = 1'b0;
        step();

        // Basic burst of three words, no backpressure
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        req_valid = 1'b1; req_len = 4'd3; m_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            req_valid = 1'b0;
            check($sformatf("basic_c%0d", k + 1), 32'(obs()), 32'(basic_exp[k]));
        end
        check("basic_req_ready", 32'(req_ready), 32'd1);

        // Backpressure: only two pops while the sink stalls
        m_ready = 1'b0; p0 = pops; h0 = hs;
        for (int i = 0; i < 4; i++) push_word(8'hA1 + 8'(i));
        req_valid = 1'b1; req_len = 4'd4;
        for (int k = 1; k <= 5; k++) begin
            step();
            req_valid = 1'b0;
            if (k >= 3) check($sformatf("bp_hold_c%0d", k), 32'({m_valid, m_data}), 32'({1'b1, 8'hA1}));
        end
        check("bp_pops_stalled", 32'(pops - p0), 32'd2);
        m_ready = 1'b1;
        wait_done(40, seen);
        check("bp_done", 32'(seen), 32'd1);
        check("bp_pops", 32'(pops - p0), 32'd4);
        check("bp_hs", 32'(hs - h0), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_word%0d", i), 32'({got_last[h0 + i], got_data[h0 + i]}),
                  32'({(i == 3), 8'hA1 + 8'(i)}));

        // Empty stall mid-burst, refill four cycles later
        p0 = pops; h0 = hs;
        push_word(8'hB1);
        req_valid = 1'b1; req_len = 4'd3; m_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("stall_first_pop", 32'(fifo_rd_en), 32'd1);
        acc = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            step();
            acc = acc | fifo_rd_en;
        end
        check("stall_no_pop", 32'(acc), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        push_word(8'hB2); push_word(8'hB3);
        wait_done(40, seen);
        check("stall_done", 32'(seen), 32'd1);
        check("stall_pops", 32'(pops - p0), 32'd3);
        check("stall_hs", 32'(hs - h0), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("stall_word%0d", i), 32'({got_last[h0 + i], got_data[h0 + i]}),
                  32'({(i == 2), 8'hB1 + 8'(i)}));

        // Zero-length request
        p0 = pops;
        req_valid = 1'b1; req_len = 4'd0;
        step();
        req_valid = 1'b0;
        check("zero_c1", 32'({done, busy, req_ready, m_valid, fifo_rd_en}), 32'(5'b10100));
        step();
        check("zero_c2", 32'({done, busy, req_ready, m_valid, fifo_rd_en}), 32'(5'b00100));
        check("zero_pops", 32'(pops - p0), 32'd0);

        // Reset mid-burst with a word buffered and another in flight
        push_word(8'hC1); push_word(8'hC2); push_word(8'hC3);
        m_ready = 1'b0; req_valid = 1'b1; req_len = 4'd3;
        step();
        req_valid = 1'b0;
        step();
        check("rstmid_pop_c2", 32'(fifo_rd_en), 32'd1);
        step();
        check("rstmid_valid_c3", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_outputs", 32'({m_valid, busy, req_ready, fifo_rd_en, done}), 32'(5'b00100));
        step();
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            acc = acc | m_valid;
        end
        check("rstmid_no_valid", 32'(acc), 32'd0);

        // Max-length burst with random backpressure; C3 is still queued in the FIFO
        for (int i = 0; i < 14; i++) push_word(8'hD0 + 8'(i));
        p0 = pops; h0 = hs;
        req_valid = 1'b1; req_len = 4'd15;
        step();
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
            if (done) seen = 1'b1;
        end
        check("max_done", 32'(seen), 32'd1);
        check("max_pops", 32'(pops - p0), 32'd15);
        check("max_hs", 32'(hs - h0), 32'd15);
        for (int i = 0; i < 15; i++)
            check($sformatf("max_word%0d", i), 32'({got_last[h0 + i], got_data[h0 + i]}),
                  32'({(i == 14), ((i == 0) ? 8'hC3 : 8'hD0 + 8'(i - 1))}));
        check("max_no_overflow", 32'(occ_ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
